// File: rtl/adc733_pkg.sv
`default_nettype none
// adc733_pkg: shared widths, record layout and FSM encoding for the ADC733 scan controller.
// Rev 1.0
package adc733_pkg;

  localparam int NUM_CH  = 8;
  localparam int CH_W    = 3;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = 8;
  localparam int REC_W   = 28;

  // Record layout, LSB first: last | data | channel | frame
  localparam int LAST_LSB  = 0;
  localparam int DATA_LSB  = 1;
  localparam int CH_LSB    = 17;
  localparam int FRAME_LSB = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DM = 2'd1,
    RUN     = 2'd2
  } state_t;

  function automatic logic [CH_W-1:0] top_channel(input logic [NUM_CH-1:0] mask);
    top_channel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) top_channel = CH_W'(i);
    end
  endfunction

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [FRAME_W-1:0] frame,
    input logic [CH_W-1:0]    ch,
    input logic [DATA_W-1:0]  data,
    input logic               last
  );
    pack_rec = {frame, ch, data, last};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc733_sample_fifo.sv
`default_nettype none
// adc733_sample_fifo: synchronous record FIFO with a registered output stage.
// Rev 1.0
module adc733_sample_fifo
  import adc733_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = REC_W
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_after_pop;

  assign full            = (count == (AW+1)'(DEPTH));
  assign wr_ok           = push & (~full | pop);
  assign rd_next         = rd_ptr + AW'(pop);
  assign count_after_pop = count - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  // The output stage only sees entries written on earlier edges, so a fresh
  // write is presented one cycle after it lands; the head is held while stalled.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_next;
      count     <= count_after_pop + (AW+1)'(wr_ok);
      out_valid <= (count_after_pop != '0);
      if (count_after_pop != '0) out_data <= mem[rd_next];
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc733_scan_ctrl.sv
`default_nettype none
// adc733_scan_ctrl: SYNC pacing, channel-mask filtering, frame tagging and buffered sample stream.
// Rev 1.0
module adc733_scan_ctrl
  import adc733_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               enable,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [15:0]        sync_period,
  input  logic               clr_status,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_rd_en,
  input  logic               adc_op_mode,
  input  logic [CH_W-1:0]    adc_channel,
  output logic               sync_o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CH_W-1:0]    out_channel,
  output logic [FRAME_W-1:0] out_frame,
  output logic               out_last,
  output logic               busy,
  output logic               frame_err,
  output logic               overflow
);

  state_t             state;
  logic [15:0]        timer;
  logic [NUM_CH-1:0]  mask_q;
  logic [NUM_CH-1:0]  seen;
  logic [FRAME_W-1:0] frame;
  logic               first_bnd;
  logic               rd_prev;
  logic               push_q;
  logic [REC_W-1:0]   rec_q;

  logic [15:0]        period_eff;
  logic               run_stay;
  logic               boundary;
  logic               rd_rise;
  logic [NUM_CH-1:0]  eff_mask;
  logic [NUM_CH-1:0]  eff_seen;
  logic [FRAME_W-1:0] eff_frame;
  logic [NUM_CH-1:0]  ch_bit;
  logic               accept;
  logic               dup;
  logic               incomplete;
  logic               mode_lost;
  logic               pop;
  logic               fifo_full;
  logic               fifo_drop;
  logic [REC_W-1:0]   fifo_out;

  assign period_eff = (sync_period < 16'(SYNC_WIDTH + 1)) ? 16'(SYNC_WIDTH + 1) : sync_period;
  assign run_stay   = (state == RUN) & enable & adc_op_mode;
  assign mode_lost  = (state == RUN) & enable & ~adc_op_mode;
  assign boundary   = run_stay & (timer == 16'd0);
  assign rd_rise    = adc_rd_en & ~rd_prev;

  // A sample arriving on a boundary belongs to the frame that boundary opens.
  assign eff_mask   = boundary ? ch_mask : mask_q;
  assign eff_seen   = boundary ? '0 : seen;
  assign eff_frame  = boundary ? frame + 8'd1 : frame;
  assign ch_bit     = NUM_CH'(1) << adc_channel;
  assign accept     = (state == RUN) & rd_rise & eff_mask[adc_channel];
  assign dup        = accept & eff_seen[adc_channel];
  assign incomplete = boundary & ~first_bnd & (seen != mask_q);

  assign pop        = out_valid & out_ready;
  assign fifo_drop  = push_q & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= IDLE;
      timer     <= '0;
      mask_q    <= '0;
      seen      <= '0;
      frame     <= '0;
      first_bnd <= 1'b0;
      rd_prev   <= 1'b0;
      push_q    <= 1'b0;
      rec_q     <= '0;
      sync_o    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rd_prev <= adc_rd_en;
      push_q  <= accept;
      if (accept) begin
        rec_q <= pack_rec(eff_frame, adc_channel, adc_data,
                          adc_channel == top_channel(eff_mask));
      end

      // A set in the same cycle as a clear wins so no error is lost.
      frame_err <= incomplete | dup | mode_lost | (frame_err & ~clr_status);
      overflow  <= fifo_drop | (overflow & ~clr_status);

      case (state)
        IDLE: begin
          sync_o <= 1'b0;
          if (enable) begin
            state <= WAIT_DM;
            busy  <= 1'b1;
          end
        end
        WAIT_DM: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (adc_op_mode) begin
            state     <= RUN;
            mask_q    <= ch_mask;
            timer     <= '0;
            first_bnd <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sync_o <= 1'b0;
          end else if (!adc_op_mode) begin
            state  <= WAIT_DM;
            sync_o <= 1'b0;
          end else begin
            sync_o <= (timer < 16'(SYNC_WIDTH));
            timer  <= (timer >= period_eff - 16'd1) ? 16'd0 : timer + 16'd1;
            if (boundary) begin
              mask_q    <= ch_mask;
              seen      <= accept ? ch_bit : '0;
              frame     <= frame + 8'd1;
              first_bnd <= 1'b0;
            end else if (accept) begin
              seen <= seen | ch_bit;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          sync_o <= 1'b0;
        end
      endcase
    end
  end

  adc733_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (push_q),
    .push_data (rec_q),
    .pop       (pop),
    .full      (fifo_full),
    .out_valid (out_valid),
    .out_data  (fifo_out)
  );

  assign out_frame   = fifo_out[FRAME_LSB +: FRAME_W];
  assign out_channel = fifo_out[CH_LSB +: CH_W];
  assign out_data    = fifo_out[DATA_LSB +: DATA_W];
  assign out_last    = fifo_out[LAST_LSB];

endmodule
`default_nettype wire
